fwd_hazard_ctrl: RTL and testbench

FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

---
 rtl/fwd_hazard_ctrl_if.sv | 42 ++++
 rtl/fwd_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_ctrl_if.sv
// rtl/fwd_hazard_ctrl_if.sv - ID-stage operand/hazard bundle for fwd_hazard_ctrl
//
// Purpose: carries the decoded ID-stage instruction into the forwarding/hazard
// controller. It also carries the controller's EX operand selects, ex_valid,
// stall and stall counter back to the pipeline.
// Ports (signals):
//   id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_use_pc, id_use_imm,
//   id_rd, id_reg_write, id_is_load, flush  : pipeline -> controller
//   A_sel[2:0], B_sel[2:0], ex_valid, stall,
//   stall_cnt[15:0]                         : controller -> pipeline
// Modports: master = pipeline side, slave = controller side.

interface fwd_hazard_ctrl_if;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic        id_use_pc;
  logic        id_use_imm;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic        id_is_load;
  logic        flush;
  logic [2:0]  A_sel;
  logic [2:0]  B_sel;
  logic        ex_valid;
  logic        stall;
  logic [15:0] stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_use_pc,
           id_use_imm, id_rd, id_reg_write, id_is_load, flush,
    input  A_sel, B_sel, ex_valid, stall, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_use_pc,
           id_use_imm, id_rd, id_reg_write, id_is_load, flush,
    output A_sel, B_sel, ex_valid, stall, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - EX operand forwarding selects and load-use stall control
//
// Purpose: tracks the two instructions ahead of ID (H1 in EX, H2 in MEM). It
// picks the EX operand sources for the ID instruction and inserts a single
// bubble on a load-use hazard.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : fwd_hazard_ctrl_if.slave (ID inputs, flush; A_sel, B_sel, ex_valid,
//          stall, stall_cnt outputs)
// Parameter STALL_CNT_MAX: saturation value of stall_cnt (0xFFFF in use).

module fwd_hazard_ctrl #(
  parameter logic [15:0] STALL_CNT_MAX = 16'hFFFF
) (
  input logic             clk,
  input logic             rst,
  fwd_hazard_ctrl_if.slave bus
);

  localparam logic [2:0] SEL_PC_D2  = 3'b000;
  localparam logic [2:0] SEL_D1_IMM = 3'b001;
  localparam logic [2:0] SEL_ALU    = 3'b010;
  localparam logic [2:0] SEL_DIN    = 3'b011;
  localparam logic [2:0] SEL_TRIM   = 3'b100;

  typedef enum logic [0:0] {RUN, LU_STALL} state_t;

  state_t      state_q, state_d;
  logic        h1_valid, h1_rw, h1_ld;
  logic [4:0]  h1_rd;
  logic        h2_valid, h2_rw, h2_ld;
  logic [4:0]  h2_rd;
  logic [2:0]  a_sel_q, b_sel_q, a_sel_d, b_sel_d;
  logic        ex_valid_q;
  logic [15:0] stall_cnt_q;
  logic        stall_c, accept, load_use;
  logic        h1_m1, h1_m2, h2_m1, h2_m2;

  function automatic logic slot_match(input logic v, input logic rw,
                                      input logic [4:0] rd, input logic [4:0] r);
    return v & rw & (rd == r) & (r != 5'd0);
  endfunction

  assign h1_m1 = slot_match(h1_valid, h1_rw, h1_rd, bus.id_rs1);
  assign h1_m2 = slot_match(h1_valid, h1_rw, h1_rd, bus.id_rs2);
  assign h2_m1 = slot_match(h2_valid, h2_rw, h2_rd, bus.id_rs1);
  assign h2_m2 = slot_match(h2_valid, h2_rw, h2_rd, bus.id_rs2);

  // A load in EX cannot forward yet; flush wins because the dependent dies anyway.
  assign load_use = bus.id_valid & !bus.flush & h1_ld &
                    ((bus.id_rs1_used & h1_m1) | (bus.id_rs2_used & h1_m2));

  always_comb begin
    state_d = state_q;
    stall_c = 1'b0;
    case (state_q)
      RUN: begin
        if (load_use && !rst) begin
          stall_c = 1'b1;
          state_d = LU_STALL;
        end
      end
      // The load has moved to MEM by now, so the held instruction forwards from H2.
      LU_STALL: state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  assign accept = bus.id_valid & !bus.flush & !stall_c;

  always_comb begin
    a_sel_d = SEL_D1_IMM;
    if (bus.id_use_pc)              a_sel_d = SEL_PC_D2;
    else if (!bus.id_rs1_used)      a_sel_d = SEL_D1_IMM;
    else if (h1_m1 && !h1_ld)       a_sel_d = SEL_ALU;
    else if (h2_m1 && h2_ld)        a_sel_d = SEL_TRIM;
    else if (h2_m1)                 a_sel_d = SEL_DIN;

    b_sel_d = SEL_PC_D2;
    if (bus.id_use_imm)             b_sel_d = SEL_D1_IMM;
    else if (!bus.id_rs2_used)      b_sel_d = SEL_PC_D2;
    else if (h1_m2 && !h1_ld)       b_sel_d = SEL_ALU;
    else if (h2_m2 && h2_ld)        b_sel_d = SEL_TRIM;
    else if (h2_m2)                 b_sel_d = SEL_DIN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      h1_valid    <= 1'b0;
      h1_rw       <= 1'b0;
      h1_ld       <= 1'b0;
      h1_rd       <= 5'd0;
      h2_valid    <= 1'b0;
      h2_rw       <= 1'b0;
      h2_ld       <= 1'b0;
      h2_rd       <= 5'd0;
      a_sel_q     <= SEL_D1_IMM;
      b_sel_q     <= SEL_PC_D2;
      ex_valid_q  <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      h2_valid <= h1_valid;
      h2_rw    <= h1_rw;
      h2_ld    <= h1_ld;
      h2_rd    <= h1_rd;
      h1_valid <= accept;
      h1_rw    <= bus.id_reg_write;
      h1_ld    <= bus.id_is_load;
      h1_rd    <= bus.id_rd;
      if (accept) begin
        a_sel_q <= a_sel_d;
        b_sel_q <= b_sel_d;
      end else begin
        a_sel_q <= SEL_D1_IMM;
        b_sel_q <= SEL_PC_D2;
      end
      ex_valid_q <= accept;
      if (stall_c && stall_cnt_q != STALL_CNT_MAX)
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.A_sel     = a_sel_q;
  assign bus.B_sel     = b_sel_q;
  assign bus.ex_valid  = ex_valid_q;
  assign bus.stall     = stall_c;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - directed self-checking bench for fwd_hazard_ctrl

module tb_fwd_hazard_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  fwd_hazard_ctrl_if bus ();

  fwd_hazard_ctrl #(.STALL_CNT_MAX(16'd7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic pc, input logic imm,
                        input logic [4:0] rd, input logic rw, input logic ld);
    bus.id_valid     = v;
    bus.id_rs1       = rs1;
    bus.id_rs2       = rs2;
    bus.id_rs1_used  = u1;
    bus.id_rs2_used  = u2;
    bus.id_use_pc    = pc;
    bus.id_use_imm   = imm;
    bus.id_rd        = rd;
    bus.id_reg_write = rw;
    bus.id_is_load   = ld;
    #1;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    nop();
    tick();
    tick();
  endtask

  // add rd, rs1, rs2 / lw rd, imm(rs1)
  task automatic add_i(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    set_id(1, rs1, rs2, 1, 1, 0, 0, rd, 1, 0);
  endtask

  task automatic lw_i(input logic [4:0] rd, input logic [4:0] rs1);
    set_id(1, rs1, 0, 1, 0, 0, 1, rd, 1, 1);
  endtask

  task automatic sels(input string tag, input int a, input int b, input int ev);
    check({tag, "_A_sel"}, int'(bus.A_sel), a);
    check({tag, "_B_sel"}, int'(bus.B_sel), b);
    check({tag, "_ex_valid"}, int'(bus.ex_valid), ev);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    bus.flush = 1'b0;
    rst = 1'b1;
    nop();

    // reset values
    tick();
    tick();
    sels("reset", 1, 0, 0);
    check("reset_stall", int'(bus.stall), 0);
    check("reset_cnt", int'(bus.stall_cnt), 0);
    rst = 1'b0;

    // add x5 ; add x6,x5,x7 -> ALU forward on A, no stall
    add_i(5, 1, 2);
    check("alu_fwd_stall0", int'(bus.stall), 0);
    tick();
    sels("alu_fwd_first", 1, 0, 1);
    add_i(6, 5, 7);
    check("alu_fwd_stall1", int'(bus.stall), 0);
    tick();
    sels("alu_fwd", 2, 0, 1);
    drain();

    // lw x5 ; add x6,x7,x5 -> one stall, bubble, then trim forward on B
    lw_i(5, 1);
    tick();
    sels("lw_imm", 1, 1, 1);
    add_i(6, 7, 5);
    check("lu_stall", int'(bus.stall), 1);
    tick();
    sels("lu_bubble", 1, 0, 0);
    check("lu_cnt", int'(bus.stall_cnt), 1);
    check("lu_second_stall", int'(bus.stall), 0);
    tick();
    sels("lu_trim", 1, 4, 1);
    check("lu_cnt_hold", int'(bus.stall_cnt), 1);
    drain();

    // add x5 ; nop ; sub x8,x5,x5 -> din forward on both
    add_i(5, 1, 2);
    tick();
    nop();
    tick();
    add_i(8, 5, 5);
    check("din_stall", int'(bus.stall), 0);
    tick();
    sels("din_fwd", 3, 3, 1);
    drain();

    // add x5 ; add x5 ; sub x8,x5,x5 -> nearest producer wins
    add_i(5, 1, 2);
    tick();
    add_i(5, 1, 2);
    tick();
    add_i(8, 5, 5);
    tick();
    sels("h1_priority", 2, 2, 1);
    drain();

    // x0 is never forwarded and never causes a load-use stall
    add_i(0, 1, 2);
    tick();
    add_i(6, 0, 3);
    tick();
    sels("x0_add", 1, 0, 1);
    drain();
    lw_i(0, 1);
    tick();
    add_i(6, 0, 3);
    check("x0_lw_stall", int'(bus.stall), 0);
    tick();
    sels("x0_lw", 1, 0, 1);
    drain();

    // flush overrides load-use
    lw_i(5, 1);
    tick();
    add_i(6, 5, 7);
    bus.flush = 1'b1;
    #1;
    check("flush_stall", int'(bus.stall), 0);
    tick();
    bus.flush = 1'b0;
    sels("flush_bubble", 1, 0, 0);
    check("flush_cnt", int'(bus.stall_cnt), 1);
    drain();

    // reset during LU_STALL aborts it; held instruction sees empty history
    lw_i(5, 1);
    tick();
    add_i(6, 5, 7);
    check("rst_mid_stall_pre", int'(bus.stall), 1);
    tick();
    check("rst_mid_cnt", int'(bus.stall_cnt), 2);
    rst = 1'b1;
    #1;
    check("rst_stall_low", int'(bus.stall), 0);
    tick();
    rst = 1'b0;
    #1;
    sels("rst_mid", 1, 0, 0);
    check("rst_mid_cnt0", int'(bus.stall_cnt), 0);
    check("rst_reeval_stall", int'(bus.stall), 0);
    tick();
    sels("rst_reeval", 1, 0, 1);
    drain();

    // saturation: lw x5,0(x5) repeated stalls every other cycle
    lw_i(5, 5);
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      tick();
    end
    check("sat_cnt6", int'(bus.stall_cnt), 6);
    check("sat_stall_again", int'(bus.stall), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      tick();
    end
    check("sat_cnt_max", int'(bus.stall_cnt), 7);
    tick();
    check("sat_cnt_hold", int'(bus.stall_cnt), 7);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
